// File: rtl/mips_cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control sequencer: states, instruction
// classes, opcode/funct/REGIMM constants, ALU operation codes and mux selects.
package mips_cpu_ctrl_pkg;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

    typedef enum logic [2:0] {
        IC_RALU, IC_JR, IC_ADDIU, IC_LW, IC_SW, IC_BRANCH, IC_J, IC_NOP
    } iclass_t;

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;
    localparam logic [5:0] OP_ADDIU  = 6'b001001;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;

    localparam logic [5:0] FN_JR     = 6'b001000;

    localparam logic [4:0] RT_BLTZ   = 5'b00000;
    localparam logic [4:0] RT_BGEZ   = 5'b00001;

    localparam logic [3:0] ALUOP_ADD   = 4'b0000;
    localparam logic [3:0] ALUOP_SUB   = 4'b0001;
    localparam logic [3:0] ALUOP_FUNCT = 4'b0010;
    localparam logic [3:0] ALUOP_BEQ   = 4'b0011;
    localparam logic [3:0] ALUOP_BGEZ  = 4'b0100;
    localparam logic [3:0] ALUOP_BGTZ  = 4'b0101;
    localparam logic [3:0] ALUOP_BLEZ  = 4'b0110;
    localparam logic [3:0] ALUOP_BLTZ  = 4'b0111;
    localparam logic [3:0] ALUOP_BNE   = 4'b1000;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

    localparam logic [1:0] TGT_ALUOUT = 2'b00;
    localparam logic [1:0] TGT_JUMP   = 2'b01;
    localparam logic [1:0] TGT_RS     = 2'b10;

endpackage

// File: rtl/mips_cpu_instr_class.sv
// Combinational instruction classifier: maps {opcode, funct, rt} to an execution
// class and, for conditional branches, the ALU comparison code.
module mips_cpu_instr_class
    import mips_cpu_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic [4:0] rt,
    output iclass_t    iclass,
    output logic [3:0] br_aluop
);

    always_comb begin
        iclass   = IC_NOP;
        br_aluop = ALUOP_ADD;
        case (opcode)
            OP_RTYPE: iclass = (funct == FN_JR) ? IC_JR : IC_RALU;
            OP_ADDIU: iclass = IC_ADDIU;
            OP_LW:    iclass = IC_LW;
            OP_SW:    iclass = IC_SW;
            OP_J:     iclass = IC_J;
            OP_BEQ:   begin iclass = IC_BRANCH; br_aluop = ALUOP_BEQ;  end
            OP_BNE:   begin iclass = IC_BRANCH; br_aluop = ALUOP_BNE;  end
            OP_BLEZ:  begin iclass = IC_BRANCH; br_aluop = ALUOP_BLEZ; end
            OP_BGTZ:  begin iclass = IC_BRANCH; br_aluop = ALUOP_BGTZ; end
            OP_REGIMM: begin
                // Unknown REGIMM rt values fall through as NOP
                if (rt == RT_BGEZ) begin
                    iclass   = IC_BRANCH;
                    br_aluop = ALUOP_BGEZ;
                end else if (rt == RT_BLTZ) begin
                    iclass   = IC_BRANCH;
                    br_aluop = ALUOP_BLTZ;
                end
            end
            default: iclass = IC_NOP;
        endcase
    end

endmodule

// File: rtl/mips_cpu_control_fsm.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB with one branch delay
// slot, and a halt after the delay slot of a jr to address 0.
module mips_cpu_control_fsm
    import mips_cpu_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic [4:0] rt,
    input  logic       waitrequest,
    input  logic       aluCond,
    input  logic       rsZero,
    output logic       memRead,
    output logic       memWrite,
    output logic       iorD,
    output logic       irWrite,
    output logic       pcWrite,
    output logic       regWrite,
    output logic       aluOutWrite,
    output logic       targetWrite,
    output logic       pcSrc,
    output logic [1:0] targetSrc,
    output logic       regDst,
    output logic       memToReg,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [3:0] aluOp,
    output logic       active
);

    state_t     state, state_next, retire_state;
    logic       branch_pending, bp_next;
    logic       halt_pending, hp_next;
    iclass_t    iclass;
    logic [3:0] br_aluop;

    mips_cpu_instr_class u_class (
        .opcode   (opcode),
        .funct    (funct),
        .rt       (rt),
        .iclass   (iclass),
        .br_aluop (br_aluop)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= FETCH;
            branch_pending <= 1'b0;
            halt_pending   <= 1'b0;
        end else begin
            state          <= state_next;
            branch_pending <= bp_next;
            halt_pending   <= hp_next;
        end
    end

    // The delay slot is the instruction whose FETCH consumed the pending redirect
    assign retire_state = (halt_pending && !branch_pending) ? HALT : FETCH;

    always_comb begin
        state_next = state;
        bp_next    = branch_pending;
        hp_next    = halt_pending;
        case (state)
            FETCH: if (!waitrequest) begin
                state_next = DECODE;
                bp_next    = 1'b0;
            end
            DECODE: state_next = EXEC;
            EXEC: begin
                case (iclass)
                    IC_RALU, IC_ADDIU: state_next = WB;
                    IC_LW, IC_SW:      state_next = MEM;
                    IC_BRANCH: begin
                        if (aluCond) bp_next = 1'b1;
                        state_next = retire_state;
                    end
                    IC_J: begin
                        bp_next    = 1'b1;
                        state_next = retire_state;
                    end
                    IC_JR: begin
                        bp_next    = 1'b1;
                        if (rsZero) hp_next = 1'b1;
                        state_next = retire_state;
                    end
                    default: state_next = retire_state;
                endcase
            end
            MEM: if (!waitrequest) state_next = (iclass == IC_LW) ? WB : retire_state;
            WB:   state_next = retire_state;
            HALT: state_next = HALT;
            default: state_next = FETCH;
        endcase
    end

    always_comb begin
        memRead     = 1'b0;
        memWrite    = 1'b0;
        iorD        = 1'b0;
        irWrite     = 1'b0;
        pcWrite     = 1'b0;
        regWrite    = 1'b0;
        aluOutWrite = 1'b0;
        targetWrite = 1'b0;
        pcSrc       = 1'b0;
        targetSrc   = TGT_ALUOUT;
        regDst      = 1'b0;
        memToReg    = 1'b0;
        aluSrcA     = 1'b0;
        aluSrcB     = SRCB_RT;
        aluOp       = ALUOP_ADD;
        active      = 1'b1;
        if (!reset) begin
            case (state)
                FETCH: begin
                    memRead = 1'b1;
                    aluSrcB = SRCB_FOUR;
                    pcSrc   = branch_pending;
                    irWrite = !waitrequest;
                    pcWrite = !waitrequest;
                end
                DECODE: begin
                    aluSrcB     = SRCB_IMM_SL2;
                    aluOutWrite = 1'b1;
                end
                EXEC: begin
                    case (iclass)
                        IC_RALU: begin
                            aluSrcA     = 1'b1;
                            aluOp       = ALUOP_FUNCT;
                            aluOutWrite = 1'b1;
                        end
                        IC_ADDIU, IC_LW, IC_SW: begin
                            aluSrcA     = 1'b1;
                            aluSrcB     = SRCB_IMM;
                            aluOutWrite = 1'b1;
                        end
                        IC_BRANCH: begin
                            aluSrcA     = 1'b1;
                            aluOp       = br_aluop;
                            targetWrite = aluCond;
                        end
                        IC_J: begin
                            targetWrite = 1'b1;
                            targetSrc   = TGT_JUMP;
                        end
                        IC_JR: begin
                            targetWrite = 1'b1;
                            targetSrc   = TGT_RS;
                        end
                        default: ;
                    endcase
                end
                MEM: begin
                    iorD     = 1'b1;
                    memRead  = (iclass == IC_LW);
                    memWrite = (iclass == IC_SW);
                end
                WB: begin
                    regWrite = 1'b1;
                    regDst   = (iclass == IC_RALU);
                    memToReg = (iclass == IC_LW);
                end
                HALT:    active = 1'b0;
                default: ;
            endcase
        end
    end

endmodule
